// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_unit
// Purpose  : IF-stage fetch unit. Owns the PC, issues one outstanding request
//            at a time to instruction memory, presents the fetched word and its
//            PC+4 to the IF/ID register, holds it across stalls and drops
//            in-flight or held words on a taken-branch redirect.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] A,
  output logic        fetch_valid,
  output logic        fetch_err
);

  // Counter wide enough to hold TIMEOUT-1 (TIMEOUT >= 2 keeps CW >= 1).
  localparam int unsigned CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ISSUE   = 3'd0,
    S_WAIT    = 3'd1,
    S_DISCARD = 3'd2,
    S_PRESENT = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t        r_state;
  logic [63:0]   r_pc;
  logic [31:0]   r_inst_q;
  logic [63:0]   r_a_q;
  logic          r_fetch_valid;
  logic [CW-1:0] r_to_cnt;

  state_t        w_state_nxt;
  logic [63:0]   w_pc_nxt;
  logic [31:0]   w_inst_nxt;
  logic [63:0]   w_a_nxt;
  logic          w_fv_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_req;

  logic [63:0]   w_target;
  logic [63:0]   w_pc_plus4;
  logic          w_unused_target_lsbs;

  // Redirect targets are word aligned; the low two bits are discarded.
  assign w_target             = {branch_target[63:2], 2'b00};
  assign w_unused_target_lsbs = ^branch_target[1:0];
  // Modulo 2^64: the top word of the address space wraps to zero.
  assign w_pc_plus4           = r_pc + 64'd4;

  // State register and datapath registers; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_ISSUE;
      r_pc          <= RESET_PC;
      r_inst_q      <= 32'd0;
      r_a_q         <= 64'd0;
      r_fetch_valid <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_inst_q      <= w_inst_nxt;
      r_a_q         <= w_a_nxt;
      r_fetch_valid <= w_fv_nxt;
      r_to_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state, datapath updates and request strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst_q;
    w_a_nxt     = r_a_q;
    w_fv_nxt    = r_fetch_valid;
    w_cnt_nxt   = r_to_cnt;
    w_req       = 1'b0;

    case (r_state)
      S_ISSUE: begin
        if (branch_taken) begin
          w_pc_nxt = w_target;
        end else begin
          w_req       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (branch_taken) begin
          w_pc_nxt = w_target;
          if (imem_valid) begin
            // Response arrives with the redirect: drop it, nothing outstanding.
            w_state_nxt = S_ISSUE;
          end else begin
            // Response still owed by memory; keep counting toward timeout.
            w_state_nxt = S_DISCARD;
            if (r_to_cnt != TO_LAST) begin
              w_cnt_nxt = r_to_cnt + CW'(1);
            end
          end
        end else if (imem_valid) begin
          w_inst_nxt  = imem_rdata;
          w_a_nxt     = w_pc_plus4;
          w_pc_nxt    = w_pc_plus4;
          w_fv_nxt    = 1'b1;
          w_state_nxt = S_PRESENT;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_to_cnt + CW'(1);
        end
      end

      S_DISCARD: begin
        if (branch_taken) begin
          w_pc_nxt = w_target;
        end
        if (imem_valid) begin
          w_state_nxt = S_ISSUE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_to_cnt + CW'(1);
        end
      end

      S_PRESENT: begin
        if (branch_taken) begin
          w_pc_nxt    = w_target;
          w_fv_nxt    = 1'b0;
          w_inst_nxt  = 32'd0;
          w_a_nxt     = 64'd0;
          w_state_nxt = S_ISSUE;
        end else if (!stall) begin
          // IF/ID captures the word this edge; next fetch overlaps it.
          w_req       = 1'b1;
          w_fv_nxt    = 1'b0;
          w_inst_nxt  = 32'd0;
          w_a_nxt     = 64'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end

      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end

      default: begin
        w_state_nxt = S_ISSUE;
      end
    endcase
  end

  // Requests are suppressed while reset is held so no strobe leaks out.
  assign imem_req    = w_req & reset;
  assign imem_addr   = r_pc;
  assign instruction = r_inst_q;
  assign A           = r_a_q;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = (r_state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a latency-programmable
//            memory model and a scoreboard of expected IF/ID words.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] A;
  logic        fetch_valid;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  logic [95:0] exp_q[$];

  // memory model controls
  logic        mem_en;
  int          mem_lat;
  logic        pend;
  int          pend_cnt;
  logic [63:0] pend_addr;

  instr_fetch_unit #(
    .RESET_PC (64'h1000),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .A             (A),
    .fetch_valid   (fetch_valid),
    .fetch_err     (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1004) return 32'h00A00093;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers each request after mem_lat cycles, in order.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    pend       = 1'b0;
    pend_cnt   = 0;
    pend_addr  = 64'd0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(pend_addr);
            pend       = 1'b0;
          end
        end
        if (imem_req && mem_en) begin
          pend      = 1'b1;
          pend_cnt  = mem_lat;
          pend_addr = imem_addr;
        end
      end
    end
  end

  // Monitor: a word is consumed when valid, not stalled and not redirected.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (fetch_valid && !stall && !branch_taken) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got inst=%h A=%h expected none", instruction, A);
          end else begin
            e = exp_q.pop_front();
            chk("word_inst", 64'(instruction), 64'(e[95:64]));
            chk("word_A", A, e[63:0]);
          end
        end else if (!fetch_valid) begin
          chk("bubble_inst", 64'(instruction), 64'd0);
          chk("bubble_A", A, 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    mem_en = 1'b1; mem_lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",  64'(imem_req), 64'd0);
    chk("rst_fv",   64'(fetch_valid), 64'd0);
    chk("rst_err",  64'(fetch_err), 64'd0);
    chk("rst_inst", 64'(instruction), 64'd0);
    chk("rst_A",    A, 64'd0);

    // sequential fetch and stall hold
    exp_q.push_back({32'h10000013, 64'h1004});
    exp_q.push_back({32'h00A00093, 64'h1008});
    exp_q.push_back({32'h10080013, 64'h100C});
    cyc(); reset = 1'b1; @(negedge clk);
    chk("c0_req", 64'(imem_req), 64'd1); chk("c0_addr", imem_addr, 64'h1000);
    cyc(); @(negedge clk);
    chk("c1_req", 64'(imem_req), 64'd0);
    cyc(); @(negedge clk);
    chk("c2_req", 64'(imem_req), 64'd1); chk("c2_addr", imem_addr, 64'h1004);
    chk("c2_fv", 64'(fetch_valid), 64'd1);
    cyc(); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc(); stall = 1'b1; @(negedge clk);
      chk("stall_req", 64'(imem_req), 64'd0);
      chk("stall_fv", 64'(fetch_valid), 64'd1);
      chk("stall_inst", 64'(instruction), 64'h00A00093);
      chk("stall_A", A, 64'h1008);
    end
    cyc(); stall = 1'b0; @(negedge clk);
    chk("unstall_req", 64'(imem_req), 64'd1); chk("unstall_addr", imem_addr, 64'h1008);
    cyc(); @(negedge clk);
    cyc(); mem_lat = 3; @(negedge clk);
    chk("c9_addr", imem_addr, 64'h100C);

    // redirect in WAIT with slow memory
    cyc(); branch_taken = 1'b1; branch_target = 64'h2003; @(negedge clk);
    chk("br_wait_req", 64'(imem_req), 64'd0);
    cyc(); branch_taken = 1'b0; @(negedge clk);
    chk("discard_req0", 64'(imem_req), 64'd0);
    cyc(); @(negedge clk);
    chk("discard_req1", 64'(imem_req), 64'd0);
    exp_q.push_back({32'h20000013, 64'h2004});
    exp_q.push_back({32'h40000013, 64'h4004});
    cyc(); mem_lat = 1; @(negedge clk);
    chk("tgt_req", 64'(imem_req), 64'd1); chk("tgt_addr", imem_addr, 64'h2000);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    chk("c15_addr", imem_addr, 64'h2004);

    // redirect coincident with response
    cyc(); branch_taken = 1'b1; branch_target = 64'h3000; @(negedge clk);
    chk("br_valid_req", 64'(imem_req), 64'd0);
    cyc(); branch_taken = 1'b0; @(negedge clk);
    chk("br_valid_nreq", 64'(imem_req), 64'd1); chk("br_valid_naddr", imem_addr, 64'h3000);
    cyc(); @(negedge clk);

    // redirect in PRESENT while stalled
    cyc(); stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h4000; @(negedge clk);
    chk("br_pres_req", 64'(imem_req), 64'd0);
    chk("br_pres_fv", 64'(fetch_valid), 64'd1);
    cyc(); stall = 1'b0; branch_taken = 1'b0; @(negedge clk);
    chk("br_pres_fv0", 64'(fetch_valid), 64'd0);
    chk("br_pres_inst0", 64'(instruction), 64'd0);
    chk("br_pres_A0", A, 64'd0);
    chk("br_pres_addr", imem_addr, 64'h4000);
    cyc(); @(negedge clk);

    // timeout
    cyc(); mem_en = 1'b0; @(negedge clk);
    chk("to_req", 64'(imem_req), 64'd1); chk("to_addr", imem_addr, 64'h4004);
    for (int i = 0; i < 16; i++) begin
      cyc(); @(negedge clk);
      chk("to_err_early", 64'(fetch_err), 64'd0);
    end
    cyc(); @(negedge clk);
    chk("to_err", 64'(fetch_err), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_en = 1'b1; branch_taken = 1'b1; branch_target = 64'h5000; @(negedge clk);
      chk("err_sticky", 64'(fetch_err), 64'd1);
      chk("err_req", 64'(imem_req), 64'd0);
    end
    cyc(); branch_taken = 1'b0; reset = 1'b0; #2;
    chk("err_clear", 64'(fetch_err), 64'd0);
    chk("q_empty_a", 64'(exp_q.size()), 64'd0);

    // address wrap and async reset
    exp_q.push_back({32'hFFFC0013, 64'h0});
    cyc(); reset = 1'b1; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; @(negedge clk);
    chk("wrap_br_req", 64'(imem_req), 64'd0);
    cyc(); branch_taken = 1'b0; @(negedge clk);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    chk("wrap_next_req", 64'(imem_req), 64'd1); chk("wrap_next_addr", imem_addr, 64'd0);
    cyc(); @(negedge clk);
    cyc(); stall = 1'b1; @(negedge clk);
    chk("pre_rst_fv", 64'(fetch_valid), 64'd1); chk("pre_rst_A", A, 64'd4);
    #1 reset = 1'b0;
    #1;
    chk("arst_fv", 64'(fetch_valid), 64'd0);
    chk("arst_inst", 64'(instruction), 64'd0);
    chk("arst_A", A, 64'd0);
    chk("arst_req", 64'(imem_req), 64'd0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    chk("q_empty_b", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
